// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - types, prefix constants and opcode attribute table for the fetch unit
//
// Purpose: shared declarations for instruction_fetch_unit.
//   sreg_index_e    : segment register index carried by a segment override
//   rep_e           : repeat prefix kind
//   ifu_state_e     : byte-assembly state
//   decoded_instr_t : one fully assembled instruction
//   decode_attrs()  : ModR/M presence and immediate size of an opcode
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    SREG_DS1 = 2'd0,
    SREG_PS  = 2'd1,
    SREG_SS  = 2'd2,
    SREG_DS0 = 2'd3
  } sreg_index_e;

  typedef enum logic [1:0] {
    REP_NONE  = 2'd0,
    REP_REP   = 2'd1,
    REP_REPNE = 2'd2
  } rep_e;

  typedef enum logic [2:0] {
    ST_PREFIX  = 3'd0,
    ST_OPCODE2 = 3'd1,
    ST_MODRM   = 3'd2,
    ST_DISP    = 3'd3,
    ST_IMM     = 3'd4,
    ST_HOLD    = 3'd5
  } ifu_state_e;

  localparam logic [7:0] PFX_SEG_DS1 = 8'h26;
  localparam logic [7:0] PFX_SEG_PS  = 8'h2E;
  localparam logic [7:0] PFX_SEG_SS  = 8'h36;
  localparam logic [7:0] PFX_SEG_DS0 = 8'h3E;
  localparam logic [7:0] PFX_REPNE   = 8'hF2;
  localparam logic [7:0] PFX_REP     = 8'hF3;
  localparam logic [7:0] PFX_LOCK    = 8'hF0;
  localparam logic [7:0] PFX_ESC_0F  = 8'h0F;

  typedef struct packed {
    logic        valid;
    sreg_index_e sreg;
  } seg_override_t;

  typedef struct packed {
    logic [7:0]    opcode;
    logic          is_0f;
    logic [7:0]    modrm;
    logic [15:0]   disp;
    logic [15:0]   imm;
    seg_override_t seg_override;
    rep_e          rep;
    logic          buslock;
    logic [3:0]    len;
    logic [15:0]   ip;
  } decoded_instr_t;

  typedef struct packed {
    logic       has_modrm;
    logic [1:0] imm_bytes;
  } op_attr_t;

  // Immediate size here is what the fetch unit must pull from the queue;
  // group opcodes whose immediate depends on ModR/M.reg (F6/F7) are left to
  // the execution unit.
  function automatic op_attr_t decode_attrs(input logic is_0f, input logic [7:0] op);
    op_attr_t a;
    a.has_modrm = 1'b0;
    a.imm_bytes = 2'd0;
    if (is_0f) begin
      a.has_modrm = 1'b1;
      // 0F 18..1F: bit operations with an imm8 bit index
      if (op[7:3] == 5'b00011) a.imm_bytes = 2'd1;
    end else if (op[7:6] == 2'b00) begin
      // ALU block 00..3F: r/m forms, then AL,imm8 and AW,imm16
      case (op[2:0])
        3'd0, 3'd1, 3'd2, 3'd3: a.has_modrm = 1'b1;
        3'd4:                   a.imm_bytes = 2'd1;
        3'd5:                   a.imm_bytes = 2'd2;
        default:                ;
      endcase
    end else begin
      case (op) inside
        8'h62:                      a.has_modrm = 1'b1;
        8'h68:                      a.imm_bytes = 2'd2;
        8'h6A:                      a.imm_bytes = 2'd1;
        8'h69:                      begin a.has_modrm = 1'b1; a.imm_bytes = 2'd2; end
        8'h6B:                      begin a.has_modrm = 1'b1; a.imm_bytes = 2'd1; end
        [8'h70:8'h7F]:              a.imm_bytes = 2'd1;
        8'h80, 8'h82, 8'h83:        begin a.has_modrm = 1'b1; a.imm_bytes = 2'd1; end
        8'h81:                      begin a.has_modrm = 1'b1; a.imm_bytes = 2'd2; end
        [8'h84:8'h8F]:              a.has_modrm = 1'b1;
        8'hA8:                      a.imm_bytes = 2'd1;
        8'hA9:                      a.imm_bytes = 2'd2;
        [8'hB0:8'hB7]:              a.imm_bytes = 2'd1;
        [8'hB8:8'hBF]:              a.imm_bytes = 2'd2;
        8'hC0, 8'hC1, 8'hC6:        begin a.has_modrm = 1'b1; a.imm_bytes = 2'd1; end
        8'hC7:                      begin a.has_modrm = 1'b1; a.imm_bytes = 2'd2; end
        8'hC2, 8'hCA:               a.imm_bytes = 2'd2;
        8'hC4, 8'hC5:               a.has_modrm = 1'b1;
        8'hCD, 8'hD4, 8'hD5:        a.imm_bytes = 2'd1;
        [8'hD0:8'hD3]:              a.has_modrm = 1'b1;
        [8'hD8:8'hDF]:              a.has_modrm = 1'b1;
        [8'hE0:8'hE7], 8'hEB:       a.imm_bytes = 2'd1;
        8'hE8, 8'hE9:               a.imm_bytes = 2'd2;
        8'hF6, 8'hF7, 8'hFE, 8'hFF: a.has_modrm = 1'b1;
        default:                    ;
      endcase
    end
    return a;
  endfunction

  function automatic logic [1:0] modrm_disp_bytes(input logic [7:0] modrm);
    logic [1:0] n;
    n = 2'd0;
    if (modrm[7:6] == 2'b01) n = 2'd1;
    else if (modrm[7:6] == 2'b10) n = 2'd2;
    else if (modrm[7:6] == 2'b00 && modrm[2:0] == 3'b110) n = 2'd2;
    return n;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - assembles V33 instructions byte by byte from the prefetch queue
//
// Ports:
//   clk, n_reset            : clock, asynchronous active-low reset
//   ce_1                    : clock enable; state advances only when high
//   ipq[8], ipq_len         : prefetch queue bytes (indexed by address[2:0]) and bytes available
//   ipq_head                : offset of the next byte to consume
//   pfp_set                 : one-tick pulse telling the queue to reload from ipq_head
//   flush, flush_ip         : redirect request and new instruction offset
//   instr_valid/ready/instr : decoded instruction handshake
//   decode_fault            : instruction grew past MAX_LEN; sticky until flush/reset
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int MAX_LEN = 15
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 ce_1,
  input  logic [7:0][7:0]      ipq,
  input  logic [3:0]           ipq_len,
  output logic [15:0]          ipq_head,
  output logic                 pfp_set,
  input  logic                 flush,
  input  logic [15:0]          flush_ip,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output decoded_instr_t       instr,
  output logic                 decode_fault
);

  localparam logic [3:0] MAX_LEN_L = 4'(MAX_LEN);

  ifu_state_e     state, state_n, base_state;
  decoded_instr_t cur, cur_n;
  logic [15:0]    head_n;
  logic           pfp_n, fault_n;
  // fld_len/fld_idx walk the little-endian bytes of the current disp/imm field;
  // imm_len remembers the opcode's immediate size across the ModR/M and disp bytes.
  logic [1:0]     fld_len, fld_len_n, imm_len, imm_len_n;
  logic           fld_idx, fld_idx_n;
  logic [7:0]     byte_in;
  op_attr_t       attr;
  logic [1:0]     disp_b;
  logic           consume, take_opcode, field_done;

  assign byte_in     = ipq[ipq_head[2:0]];
  assign instr_valid = (state == ST_HOLD);
  assign instr       = cur;

  always_comb begin
    state_n     = state;
    cur_n       = cur;
    head_n      = ipq_head;
    pfp_n       = 1'b0;
    fault_n     = decode_fault;
    fld_len_n   = fld_len;
    fld_idx_n   = fld_idx;
    imm_len_n   = imm_len;
    base_state  = state;
    consume     = 1'b0;
    take_opcode = 1'b0;
    field_done  = 1'b0;
    attr        = decode_attrs(1'b0, 8'h00);
    disp_b      = modrm_disp_bytes(byte_in);

    if (flush) begin
      head_n    = flush_ip;
      pfp_n     = 1'b1;
      cur_n     = '0;
      state_n   = ST_PREFIX;
      fault_n   = 1'b0;
      fld_len_n = 2'd0;
      fld_idx_n = 1'b0;
      imm_len_n = 2'd0;
    end else begin
      // Accept frees the slot so the next instruction's first byte can be
      // taken on the same tick.
      if (state == ST_HOLD && instr_ready) begin
        cur_n      = '0;
        base_state = ST_PREFIX;
        state_n    = ST_PREFIX;
      end
      // ipq_len is not trustworthy while the queue is reloading.
      consume = (ipq_len != 4'd0) && (base_state != ST_HOLD) && !decode_fault && !pfp_set;
      attr    = decode_attrs(base_state == ST_OPCODE2, byte_in);

      if (consume) begin
        head_n = ipq_head + 16'd1;
        if (cur_n.len == 4'd0) cur_n.ip = ipq_head;
        cur_n.len = cur_n.len + 4'd1;

        case (base_state)
          ST_PREFIX: begin
            case (byte_in)
              PFX_SEG_DS1: begin cur_n.seg_override.valid = 1'b1; cur_n.seg_override.sreg = SREG_DS1; end
              PFX_SEG_PS:  begin cur_n.seg_override.valid = 1'b1; cur_n.seg_override.sreg = SREG_PS;  end
              PFX_SEG_SS:  begin cur_n.seg_override.valid = 1'b1; cur_n.seg_override.sreg = SREG_SS;  end
              PFX_SEG_DS0: begin cur_n.seg_override.valid = 1'b1; cur_n.seg_override.sreg = SREG_DS0; end
              PFX_REPNE:   cur_n.rep = REP_REPNE;
              PFX_REP:     cur_n.rep = REP_REP;
              PFX_LOCK:    cur_n.buslock = 1'b1;
              PFX_ESC_0F:  begin cur_n.is_0f = 1'b1; state_n = ST_OPCODE2; end
              default:     take_opcode = 1'b1;
            endcase
          end
          ST_OPCODE2: take_opcode = 1'b1;
          ST_MODRM: begin
            cur_n.modrm = byte_in;
            fld_idx_n   = 1'b0;
            if (disp_b != 2'd0) begin
              fld_len_n = disp_b;
              state_n   = ST_DISP;
            end else if (imm_len != 2'd0) begin
              fld_len_n = imm_len;
              state_n   = ST_IMM;
            end else begin
              state_n = ST_HOLD;
            end
          end
          ST_DISP: begin
            if (!fld_idx)
              cur_n.disp = (fld_len == 2'd1) ? {{8{byte_in[7]}}, byte_in} : {8'h00, byte_in};
            else
              cur_n.disp[15:8] = byte_in;
            field_done = fld_idx || (fld_len == 2'd1);
            if (field_done) begin
              fld_idx_n = 1'b0;
              if (imm_len != 2'd0) begin
                fld_len_n = imm_len;
                state_n   = ST_IMM;
              end else begin
                state_n = ST_HOLD;
              end
            end else begin
              fld_idx_n = 1'b1;
            end
          end
          ST_IMM: begin
            if (!fld_idx) cur_n.imm = {8'h00, byte_in};
            else          cur_n.imm[15:8] = byte_in;
            field_done = fld_idx || (fld_len == 2'd1);
            if (field_done) begin
              fld_idx_n = 1'b0;
              state_n   = ST_HOLD;
            end else begin
              fld_idx_n = 1'b1;
            end
          end
          default: ;
        endcase

        if (take_opcode) begin
          cur_n.opcode = byte_in;
          imm_len_n    = attr.imm_bytes;
          fld_idx_n    = 1'b0;
          fld_len_n    = attr.imm_bytes;
          if (attr.has_modrm)             state_n = ST_MODRM;
          else if (attr.imm_bytes != 2'd0) state_n = ST_IMM;
          else                            state_n = ST_HOLD;
        end

        if (state_n != ST_HOLD && cur_n.len == MAX_LEN_L) fault_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state        <= ST_PREFIX;
      cur          <= '0;
      ipq_head     <= 16'd0;
      pfp_set      <= 1'b0;
      decode_fault <= 1'b0;
      fld_len      <= 2'd0;
      fld_idx      <= 1'b0;
      imm_len      <= 2'd0;
    end else if (ce_1) begin
      state        <= state_n;
      cur          <= cur_n;
      ipq_head     <= head_n;
      pfp_set      <= pfp_n;
      decode_fault <= fault_n;
      fld_len      <= fld_len_n;
      fld_idx      <= fld_idx_n;
      imm_len      <= imm_len_n;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  logic           clk = 1'b0;
  logic           n_reset;
  logic           ce_1;
  logic [7:0][7:0] ipq;
  logic [3:0]     ipq_len;
  logic [15:0]    ipq_head;
  logic           pfp_set;
  logic           flush;
  logic [15:0]    flush_ip;
  logic           instr_valid;
  logic           instr_ready;
  decoded_instr_t instr;
  logic           decode_fault;

  logic [7:0]     mem [256];
  logic [15:0]    limit;
  logic           stall;
  logic [15:0]    room;

  int n_checks = 0;
  int n_fail   = 0;
  decoded_instr_t sb [$];

  always #5 clk = ~clk;

  instruction_fetch_unit #(.MAX_LEN(15)) dut (
    .clk(clk), .n_reset(n_reset), .ce_1(ce_1), .ipq(ipq), .ipq_len(ipq_len),
    .ipq_head(ipq_head), .pfp_set(pfp_set), .flush(flush), .flush_ip(flush_ip),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .decode_fault(decode_fault)
  );

  // Queue model: bytes of mem up to (but excluding) offset 'limit' are available.
  for (genvar g = 0; g < 8; g++) begin : g_ipq
    assign ipq[g] = mem[ipq_head[7:0] + 8'(3'(3'(g) - ipq_head[2:0]))];
  end
  assign room    = limit - ipq_head;
  assign ipq_len = (stall || pfp_set) ? 4'd0 : ((room > 16'd8) ? 4'd8 : room[3:0]);

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic decoded_instr_t mk(input logic [7:0] op, input logic [7:0] modrm,
                                        input logic [15:0] disp, input logic [15:0] imm,
                                        input logic segv, input sreg_index_e sreg, input rep_e rep,
                                        input logic [3:0] len, input logic [15:0] ip);
    decoded_instr_t d;
    d = '0;
    d.opcode = op; d.modrm = modrm; d.disp = disp; d.imm = imm;
    d.seg_override.valid = segv; d.seg_override.sreg = sreg;
    d.rep = rep; d.len = len; d.ip = ip;
    return d;
  endfunction

  task automatic wait_valid();
    int k;
    k = 0;
    while (!instr_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic accept_next(input string tag);
    decoded_instr_t e;
    wait_valid();
    check({tag, "_valid"}, 96'(instr_valid), 96'd1);
    e = (sb.size() != 0) ? sb.pop_front() : decoded_instr_t'('0);
    check({tag, "_instr"}, 96'(instr), 96'(e));
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
  endtask

  initial begin
    decoded_instr_t e;
    int k;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    n_reset = 1'b0; ce_1 = 1'b1; flush = 1'b0; flush_ip = 16'h0;
    instr_ready = 1'b0; limit = 16'h0; stall = 1'b0;

    @(negedge clk);
    check("rst_head",  96'(ipq_head),     96'd0);
    check("rst_pfp",   96'(pfp_set),      96'd0);
    check("rst_valid", 96'(instr_valid),  96'd0);
    check("rst_fault", 96'(decode_fault), 96'd0);
    check("rst_instr", 96'(instr),        96'd0);

    // MOV r16, r/m16 with disp8 = -2, then a NOP waiting behind it
    mem[0] = 8'h8B; mem[1] = 8'h46; mem[2] = 8'hFE; mem[3] = 8'h90;
    limit = 16'd3;
    sb.push_back(mk(8'h8B, 8'h46, 16'hFFFE, 16'h0, 1'b0, SREG_DS1, REP_NONE, 4'd3, 16'd0));
    sb.push_back(mk(8'h90, 8'h00, 16'h0, 16'h0, 1'b0, SREG_DS1, REP_NONE, 4'd1, 16'd3));
    n_reset = 1'b1;
    wait_valid();
    check("mov_valid", 96'(instr_valid), 96'd1);
    check("mov_head",  96'(ipq_head),    96'd3);
    e = sb.pop_front();
    check("mov_instr", 96'(instr), 96'(e));
    limit = 16'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_instr", 96'(instr),    96'(e));
      check("hold_head",  96'(ipq_head), 96'd3);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    check("accept_consume_head", 96'(ipq_head), 96'd4);

    // PS: REP MOVSB
    mem[4] = 8'h2E; mem[5] = 8'hF3; mem[6] = 8'hA4;
    limit = 16'd7;
    sb.push_back(mk(8'hA4, 8'h00, 16'h0, 16'h0, 1'b1, SREG_PS, REP_REP, 4'd3, 16'd4));
    accept_next("nop");
    accept_next("movsb");

    // MOV AW, imm16 with a 5-tick queue starvation between imm bytes
    mem[7] = 8'hB8; mem[8] = 8'h34; mem[9] = 8'h12;
    limit = 16'd9;
    @(negedge clk);
    @(negedge clk);
    check("stall_head0", 96'(ipq_head), 96'd9);
    stall = 1'b1; limit = 16'd10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_head",  96'(ipq_head), 96'd9);
      check("stall_instr", 96'(instr),
            96'(mk(8'hB8, 8'h00, 16'h0, 16'h0034, 1'b0, SREG_DS1, REP_NONE, 4'd2, 16'd7)));
    end
    stall = 1'b0;
    sb.push_back(mk(8'hB8, 8'h00, 16'h0, 16'h1234, 1'b0, SREG_DS1, REP_NONE, 4'd3, 16'd7));
    accept_next("mov_imm");

    // Flush while in DISP (disp16 half received); ce_1 gating checked first
    mem[10] = 8'h8B; mem[11] = 8'h86; mem[12] = 8'h34; mem[13] = 8'h56;
    limit = 16'd13;
    repeat (3) @(negedge clk);
    check("disp_head", 96'(ipq_head), 96'd13);
    ce_1 = 1'b0; limit = 16'd14;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("ce_off_head", 96'(ipq_head), 96'd13);
    end
    ce_1 = 1'b1; flush = 1'b1; flush_ip = 16'h0100;
    @(negedge clk);
    flush = 1'b0; limit = 16'h0100;
    check("flush_pfp",   96'(pfp_set),     96'd1);
    check("flush_head",  96'(ipq_head),    96'h0100);
    check("flush_valid", 96'(instr_valid), 96'd0);
    check("flush_instr", 96'(instr),       96'd0);
    @(negedge clk);
    check("flush_pfp_off",  96'(pfp_set),  96'd0);
    check("flush_head_hold", 96'(ipq_head), 96'h0100);

    // 16 segment prefixes overrun MAX_LEN
    for (int i = 0; i < 16; i++) mem[i] = 8'h26;
    limit = 16'h0110;
    k = 0;
    while (!decode_fault && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("fault_set",  96'(decode_fault), 96'd1);
    check("fault_head", 96'(ipq_head),     96'h010F);
    repeat (2) @(negedge clk);
    check("fault_frozen_head", 96'(ipq_head),     96'h010F);
    check("fault_sticky",      96'(decode_fault), 96'd1);
    check("fault_no_valid",    96'(instr_valid),  96'd0);
    flush = 1'b1; flush_ip = 16'h0200;
    mem[0] = 8'h90;
    @(negedge clk);
    flush = 1'b0; limit = 16'h0201;
    check("fault_clear",   96'(decode_fault), 96'd0);
    check("fault_flush_pfp", 96'(pfp_set),    96'd1);
    sb.push_back(mk(8'h90, 8'h00, 16'h0, 16'h0, 1'b0, SREG_DS1, REP_NONE, 4'd1, 16'h0200));
    accept_next("post_fault_nop");
    check("sb_empty", 96'(sb.size()), 96'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Consumes bytes from the bus control unit's 8-byte prefetch queue and assembles complete V33 instructions: prefixes, opcode, ModR/M, displacement, immediate. It presents one decoded instruction at a time to the execution unit over a valid/ready handshake. It owns the queue read pointer (`ipq_head`) and the `pfp_set` flush pulse used on branches.

## Interface
Parameters:
- `MAX_LEN`, 15: maximum instruction length in bytes, prefixes included.

Ports:
- `clk`  in  1  system clock.
- `n_reset`  in  1  asynchronous, active-low reset.
- `ce_1`  in  1  clock enable; all state advances only on `ce_1`.
- `ipq`  in  8x8  prefetch queue bytes, indexed by address[2:0].
- `ipq_len`  in  4  valid bytes available from `ipq_head`.
- `ipq_head`  out  16  offset of the next byte to consume.
- `pfp_set`  out  1  one-`ce_1` pulse; the queue reloads from `ipq_head`.
- `flush`  in  1  execution unit redirect request.
- `flush_ip`  in  16  new instruction offset.
- `instr_valid`  out  1  decoded instruction is held stable.
- `instr_ready`  in  1  execution unit accepts the instruction.
- `instr`  out  `decoded_instr_t`  opcode, `is_0f`, modrm, disp[15:0], imm[15:0], `seg_override` (valid+sreg), `rep` (none/REP/REPNE), `buslock`, `len[3:0]`, `ip[15:0]`.
- `decode_fault`  out  1  `MAX_LEN` exceeded; sticky until flush or reset.

## Operation
- Reset values: `ipq_head`=0, `pfp_set`=0, `instr_valid`=0, `decode_fault`=0, `instr` all zero, state PREFIX.
- States: PREFIX, OPCODE2, MODRM, DISP, IMM, HOLD.
- A byte is consumed on a `ce_1` tick when `ipq_len`≠0 and state≠HOLD. Consuming reads `ipq[ipq_head[2:0]]`, increments `ipq_head` (16-bit wrap), and increments `len`.
- PREFIX:
  - Bytes 26/2E/36/3E set `seg_override`; the last one wins.
  - F2/F3 set `rep`.
  - F0 sets `buslock`.
  - 0F sets `is_0f` and moves to OPCODE2.
  - Any other byte is the opcode. `decode_attrs(is_0f, opcode)` returns `has_modrm` and `imm_bytes` (0/1/2). Next state is MODRM if `has_modrm`, else IMM if `imm_bytes`≠0, else HOLD.
  - `ip` latches `ipq_head` at the first byte of each instruction.
- OPCODE2: the byte is the opcode; attributes and next state are decided as for an opcode byte in PREFIX.
- MODRM: displacement bytes are mod=01→1; mod=10→2; mod=00 with rm=110→2; otherwise 0. Next state is DISP, IMM or HOLD.
- DISP: little-endian. An 8-bit displacement is sign-extended to 16 bits.
- IMM: little-endian. An 8-bit immediate is zero-extended; the execution unit sign-extends where the opcode requires it.
- HOLD: `instr_valid`=1 and `instr` is stable. When `instr_valid`&`instr_ready` on `ce_1`, clear the fields and return to PREFIX. The first byte of the next instruction may be consumed on that same tick.
- Flush, on `ce_1`:
  - `ipq_head`←`flush_ip` and `pfp_set`=1 for that tick.
  - `instr_valid`←0, fields cleared, state PREFIX, `decode_fault`←0.
  - Flush has priority over consume and over accept in the same tick.
  - No byte is consumed on the flush tick, since `ipq_len` reads 0 while `pfp_set` is high.
- `len` reaching `MAX_LEN` before HOLD sets `decode_fault` and freezes consumption until flush.

## Timing
- One byte per `ce_1` tick when bytes are available, so instruction latency in ticks equals `len` with a full queue.
- Empty queue (`ipq_len`=0): stall in the current state; no field changes.
- `instr_valid` rises on the tick after the last byte is consumed, and holds until accepted or flushed.
- `pfp_set` is registered, high for exactly one `ce_1` period, and comes one tick after `flush` is sampled.
- Async reset mid-instruction discards the partial decode at once; all outputs go to reset values.

## Structure
- `types` package: `decoded_instr_t`, `rep_e`, `ifu_state_e`, prefix byte constants, and the `decode_attrs` function (opcode attribute table). The existing `sreg_index_e` is reused for `seg_override`.
- Single module; the attribute table is a package function, so no sub-module is needed.

## Test plan
- Queue holds `8B 46 FE` at offset 0 → HOLD with opcode=8B, modrm=46, disp=FFFE, len=3, ip=0, `ipq_head`=3.
- Queue holds `2E F3 A4` → `seg_override`=PS, rep=REP, opcode=A4, len=3, no modrm.
- Bytes `B8 34` with `ipq_len` dropping to 0 for 5 ticks, then `12` → stall with no change, then imm=1234, len=3.
- `flush` with `flush_ip`=0x0100 while in DISP → `pfp_set` for one tick, `ipq_head`=0x0100, `instr_valid`=0, state PREFIX.
- 16 consecutive `26` bytes → `decode_fault`=1 after 15 consumed, `ipq_head`=15; a following flush clears it.
- `instr_ready` held low for 3 ticks in HOLD → `instr` stable and `ipq_head` unchanged; on accept, the next instruction's first byte is consumed on the same tick.
